hist_peak_finder: RTL



---
 rtl/hist_peak_finder_pkg.sv | 23 ++
 rtl/hist_peak_finder_bin_bank.sv | 61 ++++++
 rtl/hist_peak_finder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hist_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// hist_peak_finder_pkg
// Shared SiFH datapath constants for the coarse-histogram peak finder:
//   Nb / Np        coarse bin index width and TDC timestamp width
//   CNT_W_DEF      default per-bin saturating counter width
//   N_FRAMES_DEF   default number of laser frames per measurement
//   state_t        2-bit FSM state encoding used by hist_peak_finder
// -----------------------------------------------------------------------------
package hist_peak_finder_pkg;

    localparam int Nb           = 4;
    localparam int Np           = 8;
    localparam int CNT_W_DEF    = 8;
    localparam int N_FRAMES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_SCAN  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/hist_peak_finder_bin_bank.sv
// -----------------------------------------------------------------------------
// hist_bin_bank
// Bank of 2^NB saturating CNT_W-bit hit counters with one registered read port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears all bins)
//   i_clr         synchronous clear of every bin and of the read register
//   i_inc_en      increment bin i_inc_idx this edge (saturates at all-ones)
//   i_inc_idx     bin to increment
//   i_rd_idx      bin to read; data appears on o_rd_data after the next edge
//   o_rd_data     registered read data
// -----------------------------------------------------------------------------
module hist_bin_bank #(
    parameter int NB    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc_en,
    input  logic [NB-1:0]    i_inc_idx,
    input  logic [NB-1:0]    i_rd_idx,
    output logic [CNT_W-1:0] o_rd_data
);

    localparam int               NBINS   = 2 ** NB;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NBINS-1:0][CNT_W-1:0] r_bins;
    logic [CNT_W-1:0]            r_rd_data;
    logic [CNT_W-1:0]            w_inc_val;

    assign w_inc_val = (r_bins[i_inc_idx] == CNT_MAX) ? CNT_MAX
                                                      : r_bins[i_inc_idx] + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bins <= '0;
        end else if (i_clr) begin
            r_bins <= '0;
        end else if (i_inc_en) begin
            r_bins[i_inc_idx] <= w_inc_val;
        end
    end

    // The read forwards a same-edge increment so the peak finder can issue the
    // first scan read on the very edge that also counts the final hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_clr) begin
            r_rd_data <= '0;
        end else if (i_inc_en && (i_inc_idx == i_rd_idx)) begin
            r_rd_data <= w_inc_val;
        end else begin
            r_rd_data <= r_bins[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hist_peak_finder.sv
// -----------------------------------------------------------------------------
// hist_peak_finder
// Accumulates TDC timestamps into 2^NB coarse bins over N_FRAMES laser frames,
// then scans the bins (one per cycle) for the most populated one, lowest index
// winning ties. The winner is presented on peakCH / peak_count with a one-cycle
// peakReady strobe.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle pulse starting a measurement (IDLE only)
//   tdc_valid     qualifies tdc_code
//   tdc_code      TDC timestamp; top NB bits select the coarse bin
//   frame_end     one-cycle pulse at each laser period end
//   busy          high from the cycle after start through the DONE cycle
//   peakCH        winning bin index (held between measurements)
//   peak_count    winning bin hit count (held between measurements)
//   peakReady     one-cycle strobe in the DONE cycle
// -----------------------------------------------------------------------------
module hist_peak_finder
    import hist_peak_finder_pkg::*;
#(
    parameter int NB       = Nb,
    parameter int NP       = Np,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int N_FRAMES = N_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tdc_valid,
    input  logic [NP-1:0]    tdc_code,
    input  logic             frame_end,
    output logic             busy,
    output logic [NB-1:0]    peakCH,
    output logic [CNT_W-1:0] peak_count,
    output logic             peakReady
);

    localparam int FC_W = $clog2(N_FRAMES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [FC_W-1:0]    r_frame_cnt;
    logic [NB-1:0]      r_scan_idx;
    logic [NB-1:0]      r_max_idx;
    logic [CNT_W-1:0]   r_max;
    logic [NB-1:0]      r_peak_ch;
    logic [CNT_W-1:0]   r_peak_count;
    logic               r_peak_ready;
    logic               r_busy;

    logic               w_clr;
    logic               w_inc_en;
    logic [NB-1:0]      w_rd_idx;
    logic [CNT_W-1:0]   w_rd_data;
    logic               w_last_frame;
    logic               w_last_bin;
    logic               w_upd;
    logic [CNT_W-1:0]   w_cand_max;
    logic [NB-1:0]      w_cand_idx;
    logic               w_unused_lsbs;

    assign w_unused_lsbs = ^tdc_code[NP-NB-1:0];

    assign w_last_frame = (r_frame_cnt == FC_W'(N_FRAMES - 1));
    assign w_last_bin   = (r_scan_idx == {NB{1'b1}});

    // Running max; strictly-greater keeps the lowest index on ties.
    assign w_upd      = (w_rd_data > r_max);
    assign w_cand_max = w_upd ? w_rd_data  : r_max;
    assign w_cand_idx = w_upd ? r_scan_idx : r_max_idx;

    hist_bin_bank #(
        .NB    (NB),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_inc_en  (w_inc_en),
        .i_inc_idx (tdc_code[NP-1:NP-NB]),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read pipeline: bin 0 is read continuously during ACCUM, so on entering
    // SCAN its data is already registered. Each SCAN cycle compares bin
    // r_scan_idx while fetching r_scan_idx+1, giving exactly 2^NB SCAN cycles.
    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_inc_en = 1'b0;
        w_rd_idx = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_inc_en = tdc_valid;
                if (frame_end && w_last_frame) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_rd_idx = r_scan_idx + NB'(1);
                if (w_last_bin) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt  <= '0;
            r_scan_idx   <= '0;
            r_max_idx    <= '0;
            r_max        <= '0;
            r_peak_ch    <= '0;
            r_peak_count <= '0;
            r_peak_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Registered from next state so both flags line up with the state.
            r_busy       <= (w_next != ST_IDLE);
            r_peak_ready <= (w_next == ST_DONE);

            if (w_clr) begin
                r_frame_cnt <= '0;
                r_scan_idx  <= '0;
                r_max_idx   <= '0;
                r_max       <= '0;
            end

            if ((r_state == ST_ACCUM) && frame_end) begin
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end

            if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + NB'(1);
                if (w_upd) begin
                    r_max     <= w_rd_data;
                    r_max_idx <= r_scan_idx;
                end
                // The last comparison folds straight into the outputs so the
                // result is already valid in the DONE cycle.
                if (w_last_bin) begin
                    r_peak_ch    <= w_cand_idx;
                    r_peak_count <= w_cand_max;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign peakCH     = r_peak_ch;
    assign peak_count = r_peak_count;
    assign peakReady  = r_peak_ready;

endmodule
